half_subtractor_unit: RTL and testbench



---
 rtl/half_subtractor_unit.sv | 89 ++++++++
 tb/tb_half_subtractor_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/half_subtractor_unit.sv
// Single-bit half subtractor (a - b): combinational diff/borrow, a valid-qualified registered copy,
// and an optional saturating borrow-event counter enabled by `define HALF_SUB_BORROW_CNT_EN.
module half_subtractor_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             diff,
    output logic             burrow,
    output logic             diff_q,
    output logic             burrow_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] borrow_cnt,
    output logic             cnt_sat
);

    logic diff_d;
    logic burrow_d;
    logic out_valid_d;

    assign diff   = a ^ b;
    assign burrow = ~a & b;

    // Registered copy holds when no valid sample arrives; out_valid is a pure one-cycle strobe.
    always_comb begin
        diff_d      = diff_q;
        burrow_d    = burrow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            diff_d   = diff;
            burrow_d = burrow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q    <= 1'b0;
            burrow_q  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            diff_q    <= diff_d;
            burrow_q  <= burrow_d;
            out_valid <= out_valid_d;
        end
    end

`ifdef HALF_SUB_BORROW_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_full;

    assign cnt_full = (cnt_q == CntMax);

    // Clear beats a same-cycle count; the && keeps X on a/b out of the counter when not valid.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && burrow && !cnt_full) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign borrow_cnt = cnt_q;
    assign cnt_sat    = cnt_full;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign borrow_cnt     = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_half_subtractor_unit.sv
// Self-checking bench for half_subtractor_unit: directed steps plus random traffic compared
// against an arithmetic reference model; checks both an 8-bit and a 2-bit counter instance.
module tb_half_subtractor_unit;

`ifdef HALF_SUB_BORROW_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       in_valid;
    logic       cnt_clr;
    logic       diff8, burrow8, diff_q8, burrow_q8, out_valid8, cnt_sat8;
    logic       diff2, burrow2, diff_q2, burrow_q2, out_valid2, cnt_sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_dq, m_bq, m_ov, m_c8, m_c2;

    half_subtractor_unit #(.CNT_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .cnt_clr   (cnt_clr),
        .diff      (diff8),
        .burrow    (burrow8),
        .diff_q    (diff_q8),
        .burrow_q  (burrow_q8),
        .out_valid (out_valid8),
        .borrow_cnt(cnt8),
        .cnt_sat   (cnt_sat8)
    );

    half_subtractor_unit #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .cnt_clr   (cnt_clr),
        .diff      (diff2),
        .burrow    (burrow2),
        .diff_q    (diff_q2),
        .burrow_q  (burrow_q2),
        .out_valid (out_valid2),
        .borrow_cnt(cnt2),
        .cnt_sat   (cnt_sat2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input int ia, input int ib);
        // diff is the low bit of a-b, a borrow occurs when a < b.
        chk("diff8", 16'(diff8), 16'((ia - ib) & 1));
        chk("burrow8", 16'(burrow8), 16'(ia < ib));
        chk("diff2", 16'(diff2), 16'((ia - ib) & 1));
        chk("burrow2", 16'(burrow2), 16'(ia < ib));
    endtask

    task automatic chk_regs();
        chk("diff_q8", 16'(diff_q8), 16'(m_dq));
        chk("burrow_q8", 16'(burrow_q8), 16'(m_bq));
        chk("out_valid8", 16'(out_valid8), 16'(m_ov));
        chk("diff_q2", 16'(diff_q2), 16'(m_dq));
        chk("burrow_q2", 16'(burrow_q2), 16'(m_bq));
        chk("out_valid2", 16'(out_valid2), 16'(m_ov));
        chk("cnt8", 16'(cnt8), CntEn ? 16'(m_c8) : 16'd0);
        chk("cnt_sat8", 16'(cnt_sat8), 16'(CntEn && m_c8 == 255));
        chk("cnt2", 16'(cnt2), CntEn ? 16'(m_c2) : 16'd0);
        chk("cnt_sat2", 16'(cnt_sat2), 16'(CntEn && m_c2 == 3));
    endtask

    task automatic model_reset();
        m_dq = 0; m_bq = 0; m_ov = 0; m_c8 = 0; m_c2 = 0;
    endtask

    // One clock: drive at negedge, check comb, advance model at posedge, check regs #1 later.
    task automatic cycle(input int ia, input int ib, input int iv, input int ic);
        a = ia[0]; b = ib[0]; in_valid = iv[0]; cnt_clr = ic[0];
        #1 chk_comb(ia, ib);
        @(posedge clk);
        m_ov = iv;
        if (iv != 0) begin
            m_dq = (ia - ib) & 1;
            m_bq = (ia < ib) ? 1 : 0;
        end
        if (ic != 0) begin
            m_c8 = 0;
            m_c2 = 0;
        end else if (iv != 0 && ia < ib) begin
            m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
            m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
        end
        #1 chk_regs();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #1 chk_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table, not valid: registered side must stay at reset values.
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);

        // One-cycle latency then hold.
        cycle(0, 1, 1, 0);
        chk("lat_dq", 16'(diff_q8), 16'd1);
        chk("lat_ov", 16'(out_valid8), 16'd1);
        cycle(0, 0, 0, 0);
        chk("hold_bq", 16'(burrow_q8), 16'd1);
        chk("hold_ov", 16'(out_valid8), 16'd0);

        // Counting: 5 borrows interleaved with 3 non-borrows and invalid borrows.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 0);
            if (i < 3) cycle(1, 1, 1, 0);
            cycle(0, 1, 0, 0);
        end
        chk("count5", 16'(cnt8), CntEn ? 16'd5 : 16'd0);

        // Clear wins over a same-cycle borrow.
        cycle(0, 1, 1, 1);
        chk("clr_prio", 16'(cnt8), 16'd0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0);
        chk("sat_cnt2", 16'(cnt2), CntEn ? 16'd3 : 16'd0);
        chk("sat_flag2", 16'(cnt_sat2), CntEn ? 16'd1 : 16'd0);

        // Unknown operands while not valid must not disturb registered state.
        a = 1'bx; b = 1'bx; in_valid = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        m_ov = 0;
        #1 chk_regs();
        @(negedge clk);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0; a = 1'b1; b = 1'b0;
        model_reset();
        #1 chk_regs();
        chk_comb(1, 0);
        a = 1'b0; b = 1'b1;
        #1 chk_comb(0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 1, 0);
        chk("post_rst_ov", 16'(out_valid8), 16'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0) != 0), int'($urandom_range(15, 0) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
